frame_sampler: RTL
==================

// Module: frame_sampler
// PURPOSE
//  Consumes the divided sample tick from the clock-divider stage and turns it into an
//  indexed stream of NPTS input samples per FFT frame. Each tick edge captures din,
//  tags it with its in-frame index and presents it downstream on a valid/ready
//  interface. It sits between the divider and the FFT input buffer, in the same clk domain.
// PARAMETERS
//  NPTS       128  samples per frame (power of 2, >=2)
//  DW         16   sample width
//  IDXW       7    index width, = log2(NPTS)
//  BOTH_EDGES 1    1: every tick_in toggle is a strobe; 0: rising edges only
// PORTS
//  clk        in   1     system clock
//  rst        in   1     synchronous reset, active high
//  tick_in    in   1     divider output (level, toggles every N clk)
//  enable     in   1     1 = run frames continuously; 0 = stop after current frame
//  din        in   DW    sample source, stable at strobe cycle
//  out_data   out  DW    captured sample
//  out_idx    out  IDXW  index of out_data within frame, 0..NPTS-1
//  out_last   out  1     out_idx == NPTS-1, qualified by out_valid
//  out_valid  out  1     output word held
//  out_ready  in   1     downstream accepts when out_valid & out_ready
//  frame_done out  1     1-cycle pulse when a frame's last sample is accepted or dropped
//  overrun    out  1     sticky: a strobe found a held, unaccepted word
//  busy       out  1     1 while state == RUN
// BEHAVIOUR
//  - Reset: out_data=0, out_idx=0, out_last=0, out_valid=0, frame_done=0, overrun=0,
//    busy=0, cnt=0, state=IDLE; tick_q <= tick_in (no spurious strobe after reset).
//  - Strobe: BOTH_EDGES=1: tick_in ^ tick_q; BOTH_EDGES=0: tick_in & ~tick_q. tick_q <= tick_in.
//  - FSM IDLE: strobes ignored; enable=1 -> RUN next cycle, cnt=0, overrun cleared.
//  - FSM RUN, strobe in cycle t: if slot free (out_valid=0, or accepted in cycle t),
//    then in t+1 out_valid=1, out_data=din(t), out_idx=cnt, out_last=(cnt==NPTS-1).
//    Latency strobe -> out_valid = 1 cycle. Same-cycle accept + strobe: no overrun.
//  - Slot busy at strobe: new sample dropped, held word unchanged, overrun<=1 (sticky).
//  - cnt advances on every RUN strobe, captured or dropped; wraps NPTS-1 -> 0.
//  - On the strobe with cnt==NPTS-1: enable=1 -> stay RUN; enable=0 -> IDLE.
//    enable low mid-frame has no effect until that frame completes.
//  - frame_done pulses the cycle after the last-index word is accepted, or the cycle
//    after its strobe if dropped; it is also emitted if this happens after returning to IDLE.
//  - out_valid stays high, with data stable, until accepted; it clears after accept
//    with no new strobe. Outputs do not depend combinationally on out_ready.
//  - rst mid-frame: held word discarded, all state as at reset, frame index restarts at 0.
// TESTING
//  1 rst, enable=1, tick toggles every 4 clk, out_ready=1, din=idx*3 -> 128 words,
//    idx 0..127 and data 0..381, out_last only on idx 127, one frame_done, overrun=0.
//  2 BOTH_EDGES=0, same stimulus -> one word per 8 clk; idx increments by 1.
//  3 out_ready=0 during strobe 5 and 6 -> word idx 5 held; idx 6 dropped; overrun=1.
//    Next word idx 7.
//  4 Strobe in same cycle as accept of held idx 9 -> idx 10 appears next cycle,
//    overrun stays 0.
//  5 Drop enable at idx 40 -> frame completes to idx 127, frame_done, busy falls,
//    later strobes give no out_valid.
//  6 tick_in=1 at rst release; rst at idx 60 -> no strobe on release; out_valid=0,
//    next frame starts idx 0, overrun=0.

Source files
------------

// File: rtl/frame_sampler.sv
// Turns the divided sample tick into an indexed stream of NPTS samples per FFT frame,
// presented on a single-slot valid/ready output with drop-and-flag overrun handling.
`timescale 1ns/1ps

module frame_sampler #(
  parameter int NPTS       = 128,
  parameter int DW         = 16,
  parameter int IDXW       = 7,
  parameter int BOTH_EDGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_in,
  input  logic            enable,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   out_data,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            frame_done,
  output logic            overrun,
  output logic            busy,
  output logic            dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPTS - 1);

  state_t          state;
  state_t          state_nxt;
  logic            tick_q;
  logic [IDXW-1:0] cnt;

  logic strobe;
  logic accept;
  logic slot_free;
  logic run_strobe;
  logic last_strobe;
  logic capture;
  logic drop;

  // Handshake: a word transfers on any clk edge where out_valid & out_ready are both 1.
  // out_valid never waits on out_ready, and once raised it holds data/idx/last stable
  // until that transfer. The slot counts as free in the very cycle it is being accepted,
  // so a strobe landing on the accept cycle refills it without an overrun.
  assign strobe      = (BOTH_EDGES != 0) ? (tick_in ^ tick_q) : (tick_in & ~tick_q);
  assign accept      = out_valid & out_ready;
  assign slot_free   = ~out_valid | out_ready;
  assign run_strobe  = (state == RUN) & strobe;
  assign last_strobe = run_strobe & (cnt == LAST_IDX);
  assign capture     = run_strobe & slot_free;
  assign drop        = run_strobe & ~slot_free;

  assign busy      = (state == RUN);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // enable is only consulted at frame boundaries once a frame has started.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (last_strobe && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tracking the tick level through reset keeps a high tick at release from
  // looking like an edge.
  always_ff @(posedge clk) begin
    tick_q <= tick_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      out_data   <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Frame end is reported whether the last word leaves normally or is lost.
      frame_done <= (accept & out_last) | (drop & (cnt == LAST_IDX));

      if ((state == IDLE) && enable) begin
        cnt     <= '0;
        overrun <= 1'b0;
      end

      if (run_strobe) begin
        cnt <= cnt + 1'b1;
      end

      if (drop) begin
        overrun <= 1'b1;
      end

      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= din;
        out_idx   <= cnt;
        out_last  <= (cnt == LAST_IDX);
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
